// File: rtl/seg_pkg.sv
// Shared constants for the segment counter/display: radix values, the blank
// pattern and the active-low gfedcba code table for hex digits 0..F.
package seg_pkg;

    localparam int BASE_BCD = 10;
    localparam int BASE_HEX = 16;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Index 0 is the rightmost entry; bit 6 = g, bit 0 = a, low = lit.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b0100111,  // c
        7'b0000011,  // b
        7'b0100000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1011000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg_decoder.sv
// Combinational 4-bit digit to active-low 7-segment pattern.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/seg_cnt_mux.sv
// Multi-digit BCD/hex up/down counter with a time-multiplexed 7-segment driver.
// A single decoder is shared by all positions through the scan mux.
module seg_cnt_mux
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int BASE     = 10,
    parameter int TICK_DIV = 1,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [3:0]    DIGIT_TOP  = 4'(BASE - 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [PW-1:0]       presc;
    logic [SW-1:0]       scan_cnt;
    logic [IW-1:0]       idx;
    logic                step;
    logic [4*DIGITS-1:0] next_value;
    logic [4*DIGITS-1:0] load_sat;
    logic                roll;
    logic [3:0]          cur_digit;
    logic [6:0]          dec_seg;

    assign step = en && (presc == PRESC_LAST);

    // Ripple carry/borrow across digits; roll is the carry out of the top digit.
    always_comb begin : count_next
        logic       c;
        logic [3:0] d;
        next_value = value;
        c          = 1'b1;
        d          = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = value[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (d == DIGIT_TOP) begin
                        next_value[4*i +: 4] = 4'd0;
                    end else begin
                        next_value[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        next_value[4*i +: 4] = DIGIT_TOP;
                    end else begin
                        next_value[4*i +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        roll = c;
    end

    // Clamping on load keeps every stored BCD digit in 0..9.
    always_comb begin : load_clamp
        load_sat = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if ((BASE == BASE_BCD) && (load_val[4*i +: 4] > 4'd9)) begin
                load_sat[4*i +: 4] = 4'd9;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            presc <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            value <= load_sat;
            presc <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (en) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            end
            if (step) begin
                value <= next_value;
                wrap  <= roll;
            end
        end
    end

    // Scan timing is independent of counting and loading.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin : digit_mux
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx) begin
                cur_digit = value[4*i +: 4];
            end
        end
    end

    seg_decoder u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= dec_seg;
        end
    end

endmodule

// File: tb/tb_seg_cnt_mux.sv
// Bench for seg_cnt_mux: directed scenarios plus random traffic checked
// against an integer-arithmetic model of the count and the display scan.
module tb_seg_cnt_mux;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: TICK_DIV=1
    logic        rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [15:0] load_val = 16'h0;
    logic [15:0] value;
    logic        wrap;
    logic [3:0]  an;
    logic [6:0]  seg;

    // Prescaler instance: TICK_DIV=3
    logic        rst3 = 1'b1, en3 = 1'b0, up3 = 1'b1, load3 = 1'b0;
    logic [15:0] load_val3 = 16'h0;
    logic [15:0] value3;
    logic        wrap3;
    logic [3:0]  an3;
    logic [6:0]  seg3;

    seg_cnt_mux #(.DIGITS(4), .BASE(10), .TICK_DIV(1), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .value(value), .wrap(wrap), .an(an), .seg(seg)
    );

    seg_cnt_mux #(.DIGITS(4), .BASE(10), .TICK_DIV(3), .SCAN_DIV(SCAN_DIV)) dut3 (
        .clk(clk), .rst(rst3), .en(en3), .up(up3), .load(load3), .load_val(load_val3),
        .value(value3), .wrap(wrap3), .an(an3), .seg(seg3)
    );

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
        7'b0000000, 7'b0010000, 7'b0100000, 7'b0000011,
        7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: count held as a plain integer 0..9999
    int         m_n      = 0;
    int         m_tcount = 0;
    logic       m_wrap   = 1'b0;
    logic [3:0] m_an     = 4'hF;
    logic [6:0] m_seg    = 7'h7F;

    function automatic int digit_of(input int n, input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return (n / p) % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r = 16'h0;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(digit_of(n, i));
        return r;
    endfunction

    function automatic int from_load(input logic [15:0] lv);
        int r = 0;
        int p = 1;
        for (int i = 0; i < 4; i++) begin
            r = r + p * ((lv[4*i +: 4] > 4'd9) ? 9 : int'(lv[4*i +: 4]));
            p = p * 10;
        end
        return r;
    endfunction

    // Drive one cycle on the main instance and advance the model.
    task automatic cycle(input logic r, input logic e, input logic u, input logic l,
                         input logic [15:0] lv);
        rst = r; en = e; up = u; load = l; load_val = lv;
        @(posedge clk);
        if (r) begin
            m_n = 0; m_tcount = 0; m_wrap = 1'b0; m_an = 4'hF; m_seg = 7'h7F;
        end else begin
            int di;
            di = (m_tcount / SCAN_DIV) % DIGITS;
            m_an  = ~(4'b0001 << di);
            m_seg = seg_ref[digit_of(m_n, di)];
            m_tcount++;
            m_wrap = 1'b0;
            if (l) begin
                m_n = from_load(lv);
            end else if (e) begin
                if (u) begin
                    m_wrap = (m_n == 9999);
                    m_n = (m_n + 1) % 10000;
                end else begin
                    m_wrap = (m_n == 0);
                    m_n = (m_n + 9999) % 10000;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 1, 16'h5555);
        cycle(1, 0, 1, 0, 16'h0);
        checks++; if (value !== 16'h0) begin errors++; $display("FAIL reset_value got=%h exp=0000", value); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
        cycle(0, 0, 1, 0, 16'h0);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL post_reset_an got=%b exp=1110", an); end
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL post_reset_seg got=%b exp=1000000", seg); end
    endtask

    task automatic test_carry();
        cycle(0, 0, 1, 1, 16'h0999);
        checks++; if (value !== 16'h0999) begin errors++; $display("FAIL carry_load got=%h exp=0999", value); end
        cycle(0, 1, 1, 0, 16'h0);
        checks++; if (value !== 16'h1000) begin errors++; $display("FAIL carry_step got=%h exp=1000", value); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL carry_wrap got=%b exp=0", wrap); end
    endtask

    task automatic test_wrap_up();
        cycle(0, 0, 1, 1, 16'h9999);
        cycle(0, 1, 1, 0, 16'h0);
        checks++; if (value !== 16'h0000) begin errors++; $display("FAIL wrap_up_value got=%h exp=0000", value); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_up_pulse got=%b exp=1", wrap); end
        cycle(0, 0, 1, 0, 16'h0);
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_up_clear got=%b exp=0", wrap); end
    endtask

    task automatic test_wrap_down();
        cycle(0, 0, 0, 1, 16'h0000);
        cycle(0, 1, 0, 0, 16'h0);
        checks++; if (value !== 16'h9999) begin errors++; $display("FAIL wrap_dn_value got=%h exp=9999", value); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_dn_pulse got=%b exp=1", wrap); end
        cycle(0, 1, 0, 0, 16'h0);
        checks++; if (value !== 16'h9998) begin errors++; $display("FAIL wrap_dn_next got=%h exp=9998", value); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_dn_clear got=%b exp=0", wrap); end
    endtask

    task automatic test_load_priority();
        cycle(0, 0, 1, 1, 16'hFA3C);
        checks++; if (value !== 16'h9939) begin errors++; $display("FAIL load_clamp got=%h exp=9939", value); end
        cycle(0, 0, 1, 1, 16'h9999);
        cycle(0, 1, 1, 1, 16'h1234);
        checks++; if (value !== 16'h1234) begin errors++; $display("FAIL load_over_step got=%h exp=1234", value); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL load_no_wrap got=%b exp=0", wrap); end
        cycle(1, 1, 1, 1, 16'h4321);
        checks++; if (value !== 16'h0000) begin errors++; $display("FAIL rst_over_load got=%h exp=0000", value); end
    endtask

    task automatic test_scan();
        logic [3:0] an_seq  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] seg_seq [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        cycle(1, 0, 1, 0, 16'h0);
        cycle(0, 0, 1, 1, 16'h1234);
        for (int k = 1; k <= 17; k++) begin
            if (k > 1) cycle(0, 0, 1, 0, 16'h0);
            checks++;
            if (an !== an_seq[((k - 1) / 4) % 4]) begin
                errors++; $display("FAIL scan_an k=%0d got=%b exp=%b", k, an, an_seq[((k - 1) / 4) % 4]);
            end
            if (k > 1) begin
                checks++;
                if (seg !== seg_seq[((k - 1) / 4) % 4]) begin
                    errors++; $display("FAIL scan_seg k=%0d got=%b exp=%b", k, seg, seg_seq[((k - 1) / 4) % 4]);
                end
            end
        end
        cycle(0, 0, 1, 0, 16'h0);
        cycle(1, 0, 1, 0, 16'h0);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL scan_rst_an got=%b exp=1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL scan_rst_seg got=%b exp=1111111", seg); end
    endtask

    task automatic test_random();
        cycle(1, 0, 1, 0, 16'h0);
        for (int k = 0; k < 400; k++) begin
            logic       r, e, u, l;
            logic [15:0] lv;
            r  = ($urandom_range(0, 59) == 0);
            l  = ($urandom_range(0, 11) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = ($urandom_range(0, 1) == 1);
            lv = 16'($urandom);
            if ($urandom_range(0, 3) == 0) lv = ($urandom_range(0, 1) == 1) ? 16'h9998 : 16'h0001;
            cycle(r, e, u, l, lv);
            checks++;
            if (value !== to_bcd(m_n) || wrap !== m_wrap || an !== m_an || seg !== m_seg) begin
                errors++;
                $display("FAIL random k=%0d got value=%h wrap=%b an=%b seg=%b exp value=%h wrap=%b an=%b seg=%b",
                         k, value, wrap, an, seg, to_bcd(m_n), m_wrap, m_an, m_seg);
            end
        end
    endtask

    task automatic test_tick_div();
        int ens;
        rst3 = 1'b1; en3 = 1'b0; up3 = 1'b1; load3 = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b0; en3 = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        checks++; if (value3 !== 16'h0003) begin errors++; $display("FAIL tick_div_count got=%h exp=0003", value3); end
        en3 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++; if (value3 !== 16'h0003) begin errors++; $display("FAIL tick_div_hold k=%0d got=%h exp=0003", k, value3); end
        end
        ens = 9;
        for (int k = 0; k < 60; k++) begin
            en3 = ($urandom_range(0, 1) == 1);
            @(posedge clk); #1;
            if (en3) ens++;
            checks++;
            if (value3 !== to_bcd(ens / 3) || wrap3 !== 1'b0) begin
                errors++; $display("FAIL tick_div_rand k=%0d got=%h/%b exp=%h/0", k, value3, wrap3, to_bcd(ens / 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_wrap_up();
        test_wrap_down();
        test_load_priority();
        test_scan();
        test_random();
        test_tick_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
